// File: rtl/sa1d_stream_feeder.sv
// Credit-limited feeder for a 1-D systolic array: loads weights, streams IA vectors, and tags
// and buffers the clipped results. Define SA1D_FEEDER_SAT_CNT_EN to build the saturation counter.
module sa1d_stream_feeder #(
    parameter int unsigned N          = 10,
    parameter int unsigned MM_BW      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wt_valid,
    output logic                 wt_ready,
    input  logic [N*MM_BW-1:0]   wt_data,
    input  logic                 ia_valid,
    output logic                 ia_ready,
    input  logic [N*MM_BW-1:0]   ia_data,
    input  logic                 ia_last,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [7:0]           res_data,
    output logic                 res_last,
    output logic [N*MM_BW-1:0]   sa_in,
    output logic                 sa_reset_weight,
    output logic                 sa_accum_in,
    input  logic [7:0]           sa_out,
    output logic [15:0]          sat_cnt
);
    localparam int unsigned LAT  = N + 1;
    localparam int unsigned VecW = N * MM_BW;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] DepthC = (CntW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StStream} state_e;

    state_e            state_q, state_d;
    logic [VecW-1:0]   sa_in_q, sa_in_d;
    logic              sa_rw_q, sa_rw_d;
    // Stage 0 is loaded alongside sa_in; stage LAT lines up with sa_out.
    logic [LAT:0]      tag_vld_q, tag_vld_d;
    logic [LAT:0]      tag_last_q, tag_last_d;
    logic [CntW-1:0]   inflight_q, inflight_d;
    logic [CntW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [8:0]        mem_q [FIFO_DEPTH];
    logic [8:0]        mem_d [FIFO_DEPTH];

    logic              tag_in_vld, tag_in_last;
    logic [CntW:0]     credit_used;
    logic              push, pop;
    logic [8:0]        head;

    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign push        = tag_vld_q[LAT];
    assign res_valid   = (fifo_cnt_q != '0);
    assign pop         = res_valid && res_ready;
    assign head        = mem_q[rd_ptr_q];
    assign res_data    = res_valid ? head[7:0] : 8'h00;
    assign res_last    = res_valid ? head[8] : 1'b0;

    assign sa_in           = sa_in_q;
    assign sa_reset_weight = sa_rw_q;
    assign sa_accum_in     = 1'b0;

    always_comb begin
        state_d     = state_q;
        sa_in_d     = '0;
        sa_rw_d     = 1'b0;
        tag_in_vld  = 1'b0;
        tag_in_last = 1'b0;
        wt_ready    = 1'b0;
        ia_ready    = 1'b0;
        case (state_q)
            StIdle: begin
                wt_ready = 1'b1;
                if (wt_valid) begin
                    sa_in_d = wt_data;
                    sa_rw_d = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: state_d = StStream;
            StStream: begin
                // Array cannot stall: only issue when a FIFO slot is guaranteed.
                ia_ready = (credit_used < DepthC);
                if (ia_valid && ia_ready) begin
                    sa_in_d     = ia_data;
                    tag_in_vld  = 1'b1;
                    tag_in_last = ia_last;
                    if (ia_last) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tag_vld_d  = {tag_vld_q[LAT-1:0], tag_in_vld};
        tag_last_d = {tag_last_q[LAT-1:0], tag_in_last};
        inflight_d = inflight_q + CntW'(tag_in_vld) - CntW'(push);
        fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
        wr_ptr_d   = wr_ptr_q + PtrW'(push);
        rd_ptr_d   = rd_ptr_q + PtrW'(pop);
        mem_d      = mem_q;
        if (push) mem_d[wr_ptr_q] = {tag_last_q[LAT], sa_out};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sa_in_q    <= '0;
            sa_rw_q    <= 1'b0;
            tag_vld_q  <= '0;
            tag_last_q <= '0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            sa_in_q    <= sa_in_d;
            sa_rw_q    <= sa_rw_d;
            tag_vld_q  <= tag_vld_d;
            tag_last_q <= tag_last_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

`ifdef SA1D_FEEDER_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;
    logic        sat_hit;

    assign sat_hit = push && ((sa_out == 8'h7F) || (sa_out == 8'h80));

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_hit && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_cnt_q <= '0;
        else        sat_cnt_q <= sat_cnt_d;
    end

    assign sat_cnt = sat_cnt_q;
`else
    assign sat_cnt = '0;
`endif

endmodule
